// File: rtl/alu_top.sv
// Clocked signed ALU: single-cycle add/sub/mul and an iterative restoring divider
// behind a start/done handshake. Result is 2*WIDTH bits; divide packs {quotient, remainder}.
module alu_top #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   A,
  input  logic signed [WIDTH-1:0]   B,
  input  logic [1:0]                op,
  output logic signed [2*WIDTH-1:0] result,
  output logic                      done,
  output logic                      busy,
  output logic                      div_by_zero
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // S_EXEC: single-cycle op (or divide by zero) completes on the next edge.
  // S_DIV : one restoring iteration per edge.
  // S_FIX : signs applied, result/done registered.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t                    state;
  logic signed [WIDTH-1:0]   a_q;
  logic signed [WIDTH-1:0]   b_q;
  logic [1:0]                op_q;

  // Divider datapath: dvd shifts the dividend out and the quotient in.
  logic [WIDTH-1:0]          dvd;
  logic [WIDTH-1:0]          rem;
  logic [WIDTH-1:0]          dsr;
  logic                      neg_q;
  logic                      neg_r;
  logic [CW-1:0]             cnt;

  logic                      accept;
  logic                      dz_set;
  logic [WIDTH-1:0]          a_mag;
  logic [WIDTH-1:0]          b_mag;
  logic signed [RW-1:0]      a_sx;
  logic signed [RW-1:0]      b_sx;
  logic signed [RW-1:0]      sum;
  logic signed [RW-1:0]      diff;
  logic signed [RW-1:0]      prod;
  logic [WIDTH:0]            trial;
  logic                      ge;
  logic [WIDTH-1:0]          rem_nxt;
  logic [WIDTH-1:0]          dvd_nxt;
  logic [WIDTH-1:0]          q_fin;
  logic [WIDTH-1:0]          r_fin;

  // Handshake, operand magnitudes and single-cycle arithmetic on latched operands.
  // The final S_FIX cycle may accept a new start so back-to-back work loses no cycle.
  always_comb begin
    accept = start && (state != S_DIV);
    dz_set = (state == S_EXEC) && (op_q == OP_DIV);
    a_mag  = A[WIDTH-1] ? $unsigned(-A) : $unsigned(A);
    b_mag  = B[WIDTH-1] ? $unsigned(-B) : $unsigned(B);
    a_sx   = RW'(a_q);
    b_sx   = RW'(b_q);
    sum    = a_sx + b_sx;
    diff   = a_sx - b_sx;
    prod   = a_sx * b_sx;
  end

  // One restoring step: 9-bit trial so a magnitude of 128 never overflows.
  always_comb begin
    trial   = {rem, dvd[WIDTH-1]};
    ge      = (trial >= {1'b0, dsr});
    rem_nxt = ge ? WIDTH'(trial - {1'b0, dsr}) : trial[WIDTH-1:0];
    dvd_nxt = {dvd[WIDTH-2:0], ge};
    q_fin   = neg_q ? ('0 - dvd) : dvd;
    r_fin   = neg_r ? ('0 - rem) : rem;
  end

  // Control FSM and all registered outputs; acceptance overrides the completion state update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      dvd         <= '0;
      rem         <= '0;
      dsr         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      cnt         <= '0;
      result      <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        S_EXEC: begin
          done  <= 1'b1;
          state <= S_IDLE;
          case (op_q)
            OP_ADD:  result <= sum;
            OP_SUB:  result <= diff;
            OP_MUL:  result <= prod;
            default: begin
              result      <= '0;
              div_by_zero <= 1'b1;
            end
          endcase
        end
        S_DIV: begin
          dvd <= dvd_nxt;
          rem <= rem_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          result <= {q_fin, r_fin};
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
        end
      endcase

      if (accept) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op;
        if (!dz_set) begin
          div_by_zero <= 1'b0;
        end
        if ((op == OP_DIV) && (B != '0)) begin
          state <= S_DIV;
          busy  <= 1'b1;
          dvd   <= a_mag;
          dsr   <= b_mag;
          rem   <= '0;
          cnt   <= '0;
          neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
          neg_r <= A[WIDTH-1];
        end else begin
          state <= S_EXEC;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: directed table, control sequences and random ops vs a model.
module tb_alu_top;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [7:0]  A;
  logic signed [7:0]  B;
  logic [1:0]         op;
  logic signed [15:0] result;
  logic               done;
  logic               busy;
  logic               div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic [1:0]        op;
    logic [15:0]       res;
    logic              dbz;
    int                lat;
  } vec_t;

  alu_top #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .op(op),
    .result(result), .done(done), .busy(busy), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mkv(input int a, input int b, input int o,
                               input int res, input int dbz, input int lat);
    vec_t v;
    v.a   = 8'(a);
    v.b   = 8'(b);
    v.op  = 2'(o);
    v.res = 16'(res);
    v.dbz = 1'(dbz);
    v.lat = lat;
    return v;
  endfunction

  // Reference: plain integer arithmetic; SV int division truncates and % follows the dividend.
  function automatic vec_t model(input logic signed [7:0] a, input logic signed [7:0] b,
                                 input logic [1:0] o);
    int ai, bi, r, q, m;
    vec_t v;
    ai = int'(a);
    bi = int'(b);
    v.a = a; v.b = b; v.op = o; v.dbz = 1'b0; v.lat = 1;
    r = 0;
    case (o)
      2'd0: r = ai + bi;
      2'd1: r = ai - bi;
      2'd2: r = ai * bi;
      default: begin
        if (bi == 0) begin
          r = 0;
          v.dbz = 1'b1;
        end else begin
          q = ai / bi;
          m = ai % bi;
          r = ((q & 255) << 8) | (m & 255);
          v.lat = 9;
        end
      end
    endcase
    v.res = 16'(r);
    return v;
  endfunction

  // Issue one op, scramble inputs after acceptance, wait (bounded) for done.
  task automatic run_op(input logic signed [7:0] a, input logic signed [7:0] b,
                        input logic [1:0] o, input logic exp_busy,
                        output logic [15:0] res, output logic dbz,
                        output int lat, output logic ctl_ok);
    res = '0; dbz = 1'b0; lat = 0; ctl_ok = 1'b1;
    @(negedge clk);
    A = a; B = b; op = o; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A = 8'($urandom); B = 8'($urandom); op = 2'($urandom);
    if (busy != exp_busy || done) ctl_ok = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        res = result;
        dbz = div_by_zero;
        if (busy) ctl_ok = 1'b0;
        break;
      end else if (busy != exp_busy) begin
        ctl_ok = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (done) ctl_ok = 1'b0;
  endtask

  task automatic apply(input string tag, input vec_t v);
    logic [15:0] r;
    logic        z;
    int          l;
    logic        ok;
    run_op(v.a, v.b, v.op, (v.op == 2'd3) && (v.b != 0), r, z, l, ok);
    check({tag, "_result"}, int'(r), int'(v.res));
    check({tag, "_dbz"}, int'(z), int'(v.dbz));
    check({tag, "_latency"}, l, v.lat);
    check({tag, "_busy_done_shape"}, int'(ok), 1);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    int   cnt;

    rst = 1'b1; start = 1'b0; A = '0; B = '0; op = '0;

    vecs.push_back(mkv( 100,    5, 0, 16'h0069, 0, 1));
    vecs.push_back(mkv(-100,    5, 1, 16'hFF97, 0, 1));
    vecs.push_back(mkv(-128,  127, 1, 16'hFF01, 0, 1));
    vecs.push_back(mkv(  10,    3, 2, 16'h001E, 0, 1));
    vecs.push_back(mkv(-128, -128, 2, 16'h4000, 0, 1));
    vecs.push_back(mkv( 127,  127, 0, 16'h00FE, 0, 1));
    vecs.push_back(mkv(-100,    5, 3, 16'hEC00, 0, 9));
    vecs.push_back(mkv(   7,   -2, 3, 16'hFD01, 0, 9));
    vecs.push_back(mkv(  -7,    2, 3, 16'hFDFF, 0, 9));
    vecs.push_back(mkv(-128,   -1, 3, 16'h8000, 0, 9));
    vecs.push_back(mkv(-128,    1, 3, 16'h8000, 0, 9));
    vecs.push_back(mkv( 127, -128, 3, 16'h007F, 0, 9));
    vecs.push_back(mkv(  50,    0, 3, 16'h0000, 1, 1));
    vecs.push_back(mkv(   1,    1, 0, 16'h0002, 0, 1));

    repeat (2) @(negedge clk);
    check("reset_outputs", int'({result, done, busy, div_by_zero}), 0);
    rst = 1'b0;

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Result holds between completions.
    repeat (3) @(negedge clk);
    check("hold_result", int'(result), 16'h0002);
    check("hold_done_low", int'(done), 0);

    // start pulses during a division are ignored.
    @(negedge clk);
    A = 8'sd100; B = 8'sd7; op = 2'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; A = 8'sd1; B = 8'sd1; op = 2'd0;
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && cnt == 0; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt = 1;
    end
    check("busy_start_done_seen", cnt, 1);
    check("busy_start_result", int'(result), 16'h0E02);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("busy_start_no_extra_done", cnt, 0);

    // Reset in the middle of a division aborts it.
    @(negedge clk);
    A = -8'sd90; B = 8'sd7; op = 2'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid_div_outputs", int'({result, done, busy, div_by_zero}), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("rst_mid_div_no_done", cnt, 0);
    check("rst_mid_div_busy", int'(busy), 0);

    // Fresh start after reset.
    apply("post_reset_div", mkv(-100, 5, 3, 16'hEC00, 0, 9));

    // Randomized ops against the model.
    for (int i = 0; i < 150; i++) begin
      logic signed [7:0] ra, rb;
      logic [1:0]        ro;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'sd0 : 8'($urandom);
      ro = 2'($urandom);
      v = model(ra, rb, ro);
      apply($sformatf("rnd%0d_op%0d_%0d_%0d", i, ro, ra, rb), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
